// File: rtl/register_file_mp.sv
// Two-write-port register file with fixed port-B priority, optional hardwired
// zero register, optional write-to-read bypass and a sequential clear sweep.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [DATA_W-1:0] wd_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              sweep;
    logic              wr_a;
    logic              wr_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // The reset edge itself leaves the array alone; the sweep does the clearing.
    always_comb begin
        busy  = (state_q == CLEAR);
        sweep = busy && rst_n;
        wr_a  = !busy && rst_n && we_a
                && !((ZERO_REG != 0) && (wa_a == '0));
        wr_b  = !busy && rst_n && we_b
                && !((ZERO_REG != 0) && (wa_b == '0));
    end

    // Port B is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (sweep) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr_a) begin
                mem_q[wa_a] <= wd_a;
            end
            if (wr_b) begin
                mem_q[wa_b] <= wd_b;
            end
        end
    end

    function automatic logic [DATA_W-1:0] rd_sel(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] r;
        if (busy) begin
            r = '0;
        end else if ((ZERO_REG != 0) && (ra == '0)) begin
            r = '0;
        end else if ((BYPASS != 0) && we_b && (wa_b == ra)) begin
            r = wd_b;
        end else if ((BYPASS != 0) && we_a && (wa_a == ra)) begin
            r = wd_a;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    always_comb begin
        rd1 = rd_sel(ra1, mem_q[ra1]);
        rd2 = rd_sel(ra2, mem_q[ra2]);
    end

endmodule
